// File: rtl/ten_gig_mac_tx_arbiter.sv
// Packet-granular 2:1 round-robin arbiter in front of the 10G MAC TX stream input.
// Grant is held from first beat to tlast; the output beat is registered; packets are counted per port.
module ten_gig_mac_tx_arbiter #(
    parameter int unsigned P_DATA_W = 64,
    parameter int unsigned P_USER_W = 80,
    parameter int unsigned P_CNT_W  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [P_DATA_W-1:0]   s0_axis_tdata,
    input  logic [P_USER_W-1:0]   s0_axis_tuser,
    input  logic [P_DATA_W/8-1:0] s0_axis_tkeep,
    input  logic                  s0_axis_tlast,
    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,
    input  logic [P_DATA_W-1:0]   s1_axis_tdata,
    input  logic [P_USER_W-1:0]   s1_axis_tuser,
    input  logic [P_DATA_W/8-1:0] s1_axis_tkeep,
    input  logic                  s1_axis_tlast,
    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,
    output logic [P_DATA_W-1:0]   m_axis_tdata,
    output logic [P_USER_W-1:0]   m_axis_tuser,
    output logic [P_DATA_W/8-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [1:0]            o_grant,
    output logic [P_CNT_W-1:0]    o_pkt_cnt0,
    output logic [P_CNT_W-1:0]    o_pkt_cnt1
);

    typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_t;

    state_t                state, state_next;
    logic                  rr, rr_next;  // 0 favours port 0 on a tie
    logic                  out_free;
    logic                  acc0, acc1, acc;
    logic [P_DATA_W-1:0]   beat_data;
    logic [P_USER_W-1:0]   beat_user;
    logic [P_DATA_W/8-1:0] beat_keep;
    logic                  beat_last;

    // Output slot can take a new beat when empty or draining this cycle.
    assign out_free = ~m_axis_tvalid | m_axis_tready;

    always_comb begin
        s0_axis_tready = (state == StLock0) & out_free;
        s1_axis_tready = (state == StLock1) & out_free;
        acc0           = s0_axis_tvalid & s0_axis_tready;
        acc1           = s1_axis_tvalid & s1_axis_tready;
        acc            = acc0 | acc1;
        if (state == StLock1) begin
            beat_data = s1_axis_tdata;
            beat_user = s1_axis_tuser;
            beat_keep = s1_axis_tkeep;
            beat_last = s1_axis_tlast;
        end else begin
            beat_data = s0_axis_tdata;
            beat_user = s0_axis_tuser;
            beat_keep = s0_axis_tkeep;
            beat_last = s0_axis_tlast;
        end
    end

    always_comb begin
        state_next = state;
        rr_next    = rr;
        unique case (state)
            StIdle: begin
                if (s0_axis_tvalid && (!s1_axis_tvalid || !rr)) begin
                    state_next = StLock0;
                end else if (s1_axis_tvalid) begin
                    state_next = StLock1;
                end
            end
            StLock0: begin
                if (acc0 && s0_axis_tlast) begin
                    state_next = StIdle;
                    rr_next    = 1'b1;
                end
            end
            StLock1: begin
                if (acc1 && s1_axis_tlast) begin
                    state_next = StIdle;
                    rr_next    = 1'b0;
                end
            end
            default: state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state         <= StIdle;
            rr            <= 1'b0;
            o_grant       <= 2'b00;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            o_pkt_cnt0    <= '0;
            o_pkt_cnt1    <= '0;
        end else begin
            state   <= state_next;
            rr      <= rr_next;
            o_grant <= {state_next == StLock1, state_next == StLock0};
            if (acc) begin
                m_axis_tdata  <= beat_data;
                m_axis_tuser  <= beat_user;
                m_axis_tkeep  <= beat_keep;
                m_axis_tlast  <= beat_last;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (acc0 && s0_axis_tlast) begin
                o_pkt_cnt0 <= o_pkt_cnt0 + P_CNT_W'(1);
            end
            if (acc1 && s1_axis_tlast) begin
                o_pkt_cnt1 <= o_pkt_cnt1 + P_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ten_gig_mac_tx_arbiter.sv
// Directed bench for ten_gig_mac_tx_arbiter: per-port beat queues drive the requesters,
// a monitor captures output beats, and expected packet order is listed by hand per scenario.
module tb_ten_gig_mac_tx_arbiter;

    typedef struct {
        logic [63:0] data;
        logic [79:0] user;
        logic [7:0]  keep;
        logic        last;
        int          gap;
    } beat_t;

    logic        i_clk, i_rst;
    logic [63:0] s0_tdata, s1_tdata, m_tdata;
    logic [79:0] s0_tuser, s1_tuser, m_tuser;
    logic [7:0]  s0_tkeep, s1_tkeep, m_tkeep;
    logic        s0_tlast, s1_tlast, m_tlast;
    logic        s0_tvalid, s1_tvalid, m_tvalid;
    logic        s0_tready, s1_tready, m_tready;
    logic [1:0]  grant;
    logic [15:0] cnt0, cnt1;

    logic        w_s0_tvalid, w_s0_tready, w_s1_tready;
    logic [63:0] w_m_tdata;
    logic [79:0] w_m_tuser;
    logic [7:0]  w_m_tkeep;
    logic        w_m_tlast, w_m_tvalid;
    logic [1:0]  w_grant;
    logic [3:0]  w_cnt0, w_cnt1;

    beat_t q0[$], q1[$], out_q[$], exp_q[$];
    int    out_cyc[$];
    int    cyc, n_checks, n_pass, gap0, gap1, req;
    logic  acc0, acc1, hold_v;
    beat_t held;

    ten_gig_mac_tx_arbiter dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .s0_axis_tdata(s0_tdata), .s0_axis_tuser(s0_tuser), .s0_axis_tkeep(s0_tkeep),
        .s0_axis_tlast(s0_tlast), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready),
        .s1_axis_tdata(s1_tdata), .s1_axis_tuser(s1_tuser), .s1_axis_tkeep(s1_tkeep),
        .s1_axis_tlast(s1_tlast), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready),
        .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tkeep(m_tkeep),
        .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .o_grant(grant), .o_pkt_cnt0(cnt0), .o_pkt_cnt1(cnt1)
    );

    // Narrow-counter instance so the wrap can be reached in a few dozen cycles.
    ten_gig_mac_tx_arbiter #(.P_CNT_W(4)) dut_wrap (
        .i_clk(i_clk), .i_rst(i_rst),
        .s0_axis_tdata(64'h0), .s0_axis_tuser(80'h0), .s0_axis_tkeep(8'hFF),
        .s0_axis_tlast(1'b1), .s0_axis_tvalid(w_s0_tvalid), .s0_axis_tready(w_s0_tready),
        .s1_axis_tdata(64'h0), .s1_axis_tuser(80'h0), .s1_axis_tkeep(8'hFF),
        .s1_axis_tlast(1'b1), .s1_axis_tvalid(1'b0), .s1_axis_tready(w_s1_tready),
        .m_axis_tdata(w_m_tdata), .m_axis_tuser(w_m_tuser), .m_axis_tkeep(w_m_tkeep),
        .m_axis_tlast(w_m_tlast), .m_axis_tvalid(w_m_tvalid), .m_axis_tready(1'b1),
        .o_grant(w_grant), .o_pkt_cnt0(w_cnt0), .o_pkt_cnt1(w_cnt1)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge i_clk);
            cyc++;
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic beat_t mk_beat(int port, int pkt, int beat, int n, logic [7:0] last_keep);
        beat_t b;
        b.data = {8'hA0 + 8'(port), 8'(pkt), 8'(beat), 40'h11_2233_4455};
        b.user = {16'hBEEF, 8'(port), 8'(pkt), 8'(beat), 40'h0};
        b.keep = (beat == n - 1) ? last_keep : 8'hFF;
        b.last = (beat == n - 1);
        b.gap  = 0;
        return b;
    endfunction

    task automatic push_pkt(int port, int pkt, int n, int gap_beat, int gap_len,
                            logic [7:0] last_keep);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b = mk_beat(port, pkt, i, n, last_keep);
            if (i == gap_beat) b.gap = gap_len;
            if (port == 0) q0.push_back(b);
            else q1.push_back(b);
        end
    endtask

    task automatic expect_pkt(int port, int pkt, int n, logic [7:0] last_keep);
        for (int i = 0; i < n; i++) exp_q.push_back(mk_beat(port, pkt, i, n, last_keep));
    endtask

    task automatic wait_out(int n, int budget, string tag);
        int k = 0;
        while (out_q.size() < n && k < budget) begin
            @(negedge i_clk);
            #1;
            k++;
        end
        if (out_q.size() < n) check_eq({tag, ".timeout"}, out_q.size(), n);
    endtask

    task automatic compare_out(string tag);
        check_eq({tag, ".count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            check_eq($sformatf("%s.data%0d", tag, i), out_q[i].data, exp_q[i].data);
            check_eq($sformatf("%s.user%0d", tag, i), out_q[i].user, exp_q[i].user);
            check_eq($sformatf("%s.keep%0d", tag, i), out_q[i].keep, exp_q[i].keep);
            check_eq($sformatf("%s.last%0d", tag, i), out_q[i].last, exp_q[i].last);
        end
    endtask

    task automatic do_reset();
        i_rst    = 1'b0;
        m_tready = 1'b1;
        q0.delete();
        q1.delete();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        out_q.delete();
        out_cyc.delete();
        exp_q.delete();
    endtask

    // Requester drivers: a beat is retired after the edge at which valid&ready was seen.
    initial begin
        s0_tvalid = 1'b0; s0_tdata = '0; s0_tuser = '0; s0_tkeep = '0; s0_tlast = 1'b0;
        gap0 = 0;
        forever begin
            @(negedge i_clk);
            acc0 = s0_tvalid && s0_tready;
            @(posedge i_clk);
            #1;
            if (acc0 && q0.size() > 0) begin
                q0.delete(0);
                gap0 = (q0.size() > 0) ? q0[0].gap : 0;
            end
            if (!i_rst) gap0 = 0;
            if (gap0 > 0) begin
                gap0--;
                s0_tvalid = 1'b0;
            end else if (q0.size() > 0) begin
                s0_tvalid = 1'b1;
                s0_tdata  = q0[0].data; s0_tuser = q0[0].user;
                s0_tkeep  = q0[0].keep; s0_tlast = q0[0].last;
            end else begin
                s0_tvalid = 1'b0;
            end
        end
    end

    initial begin
        s1_tvalid = 1'b0; s1_tdata = '0; s1_tuser = '0; s1_tkeep = '0; s1_tlast = 1'b0;
        gap1 = 0;
        forever begin
            @(negedge i_clk);
            acc1 = s1_tvalid && s1_tready;
            @(posedge i_clk);
            #1;
            if (acc1 && q1.size() > 0) begin
                q1.delete(0);
                gap1 = (q1.size() > 0) ? q1[0].gap : 0;
            end
            if (!i_rst) gap1 = 0;
            if (gap1 > 0) begin
                gap1--;
                s1_tvalid = 1'b0;
            end else if (q1.size() > 0) begin
                s1_tvalid = 1'b1;
                s1_tdata  = q1[0].data; s1_tuser = q1[0].user;
                s1_tkeep  = q1[0].keep; s1_tlast = q1[0].last;
            end else begin
                s1_tvalid = 1'b0;
            end
        end
    end

    // Output monitor: captures handshakes and checks the beat is held while stalled.
    initial begin
        beat_t b;
        hold_v = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check_eq("stall.valid", m_tvalid, 1'b1);
                    check_eq("stall.data", m_tdata, held.data);
                    check_eq("stall.user", m_tuser, held.user);
                    check_eq("stall.keeplast", {m_tkeep, m_tlast}, {held.keep, held.last});
                end
                if (m_tvalid && m_tready) begin
                    b.data = m_tdata; b.user = m_tuser; b.keep = m_tkeep; b.last = m_tlast;
                    b.gap  = 0;
                    out_q.push_back(b);
                    out_cyc.push_back(cyc);
                end
                hold_v    = m_tvalid && !m_tready;
                held.data = m_tdata; held.user = m_tuser;
                held.keep = m_tkeep; held.last = m_tlast;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        n_checks    = 0;
        n_pass      = 0;
        i_rst       = 1'b0;
        m_tready    = 1'b1;
        w_s0_tvalid = 1'b0;

        // 1: single 3-beat packet from port 0, 2-cycle latency from request
        do_reset();
        check_eq("t1.rst_grant", grant, 2'b00);
        check_eq("t1.rst_valid", m_tvalid, 1'b0);
        push_pkt(0, 0, 3, -1, 0, 8'h0F);
        expect_pkt(0, 0, 3, 8'h0F);
        @(posedge i_clk);
        #2;
        req = cyc;
        wait_out(3, 20, "t1");
        for (int i = 0; i < 3 && i < out_cyc.size(); i++)
            check_eq($sformatf("t1.cycle%0d", i), out_cyc[i], req + 2 + i);
        compare_out("t1");
        check_eq("t1.cnt0", cnt0, 16'd1);
        check_eq("t1.cnt1", cnt1, 16'd0);
        check_eq("t1.grant_idle", grant, 2'b00);

        // 2: both ports contend, packets alternate s0,s1,s0,s1
        do_reset();
        push_pkt(0, 0, 4, -1, 0, 8'hFF);
        push_pkt(0, 1, 4, -1, 0, 8'hFF);
        push_pkt(1, 0, 4, -1, 0, 8'hFF);
        push_pkt(1, 1, 4, -1, 0, 8'hFF);
        expect_pkt(0, 0, 4, 8'hFF);
        expect_pkt(1, 0, 4, 8'hFF);
        expect_pkt(0, 1, 4, 8'hFF);
        expect_pkt(1, 1, 4, 8'hFF);
        wait_out(16, 200, "t2");
        compare_out("t2");
        check_eq("t2.cnt0", cnt0, 16'd2);
        check_eq("t2.cnt1", cnt1, 16'd2);

        // 3: m_tready 1,0,0,1 while a packet is in flight
        do_reset();
        push_pkt(0, 3, 4, -1, 0, 8'h3F);
        expect_pkt(0, 3, 4, 8'h3F);
        k = 0;
        while (!m_tvalid && k < 20) begin
            @(negedge i_clk);
            k++;
        end
        check_eq("t3.first_valid", m_tvalid, 1'b1);
        @(posedge i_clk); #1; m_tready = 1'b0;
        @(posedge i_clk); #1; m_tready = 1'b0;
        @(posedge i_clk); #1; m_tready = 1'b1;
        wait_out(4, 50, "t3");
        compare_out("t3");
        check_eq("t3.cnt0", cnt0, 16'd1);

        // 4: port 1 bubbles mid-packet, port 0 must wait for its tlast
        do_reset();
        push_pkt(1, 0, 4, 2, 2, 8'hFF);
        k = 0;
        while (grant != 2'b10 && k < 20) begin
            @(negedge i_clk);
            k++;
        end
        check_eq("t4.grant1", grant, 2'b10);
        push_pkt(0, 0, 3, -1, 0, 8'hFF);
        repeat (3) @(negedge i_clk);
        check_eq("t4.bubble_grant", grant, 2'b10);
        check_eq("t4.bubble_s0_ready", s0_tready, 1'b0);
        expect_pkt(1, 0, 4, 8'hFF);
        expect_pkt(0, 0, 3, 8'hFF);
        wait_out(7, 100, "t4");
        compare_out("t4");

        // 5: reset on beat 2 of a port-0 packet, then a clean port-1 packet
        do_reset();
        push_pkt(1, 0, 2, -1, 0, 8'hFF);
        wait_out(2, 30, "t5a");
        push_pkt(0, 0, 4, -1, 0, 8'hFF);
        wait_out(3, 30, "t5b");
        @(posedge i_clk);
        #2;
        check_eq("t5.pre_valid", m_tvalid, 1'b1);
        check_eq("t5.pre_cnt1", cnt1, 16'd1);
        i_rst = 1'b0;
        #1;
        check_eq("t5.rst_valid", m_tvalid, 1'b0);
        check_eq("t5.rst_data", m_tdata, 64'h0);
        check_eq("t5.rst_user", m_tuser, 80'h0);
        check_eq("t5.rst_keeplast", {m_tkeep, m_tlast}, 9'h0);
        check_eq("t5.rst_grant", grant, 2'b00);
        check_eq("t5.rst_ready", {s0_tready, s1_tready}, 2'b00);
        check_eq("t5.rst_cnt", {cnt0, cnt1}, 32'h0);
        q0.delete();
        q1.delete();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        out_q.delete();
        out_cyc.delete();
        exp_q.delete();
        push_pkt(1, 5, 3, -1, 0, 8'h01);
        expect_pkt(1, 5, 3, 8'h01);
        wait_out(3, 30, "t5");
        repeat (4) @(negedge i_clk);
        compare_out("t5");
        check_eq("t5.cnt0", cnt0, 16'd0);
        check_eq("t5.cnt1", cnt1, 16'd1);

        // 6: counter wrap on a 4-bit instance, one single-beat packet every 2 cycles
        do_reset();
        @(posedge i_clk);
        #1;
        w_s0_tvalid = 1'b1;
        repeat (30) @(posedge i_clk);
        @(negedge i_clk);
        check_eq("t6.cnt_max", w_cnt0, 4'hF);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check_eq("t6.cnt_wrap", w_cnt0, 4'h0);
        check_eq("t6.cnt1", w_cnt1, 4'h0);
        w_s0_tvalid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
